reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 8x8 register file: configurable data width and register count, two registered read ports and one write port.
- Adds write enable, read enable with valid flag, write-to-read bypass, an optional hardwired zero register, and a synchronous clear-all.
- Sits between instruction decode and the ALU. Read results feed the ALU DATA1/DATA2; the ALU Result returns on IN.
- Single clock edge (posedge clk) for both reads and writes.

Parameters:
- DATA_W, 8: register width in bits, 1..64.
- ADDR_W, 3: address width; register count DEPTH = 2**ADDR_W, 2..64 registers.
- ZERO_REG, 0: 1 = register 0 always reads 0 and writes to it are discarded; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset; clock clk.
- CLEAR  input  1  synchronous clear of all registers.
- WRITE  input  1  write enable.
- INaddr  input  ADDR_W  write address.
- IN  input  DATA_W  write data.
- READ  input  1  read enable for both ports.
- OUT1addr  input  ADDR_W  read port 1 address.
- OUT2addr  input  ADDR_W  read port 2 address.
- OUT1  output  DATA_W  read port 1 data (registered).
- OUT2  output  DATA_W  read port 2 data (registered).
- OUT_VALID  output  1  OUT1/OUT2 hold data from a READ sampled on the previous edge.

Behaviour:
- Reset (RESET=1, asynchronous):
  - All registers, OUT1, OUT2 = 0; OUT_VALID = 0.
  - Holds while RESET is high.
  - Deassertion is not synchronised internally; the system synchronises it externally.
- Write: at posedge with WRITE=1 and CLEAR=0, reg[INaddr] <= IN. With WRITE=0 there is no change.
- Read: at posedge with READ=1:
  - OUT1 <= value(OUT1addr); OUT2 <= value(OUT2addr); OUT_VALID <= 1.
  - Latency is 1 cycle from the address-sampling edge.
- Read idle: at posedge with READ=0, OUT1 and OUT2 hold their previous values and OUT_VALID <= 0.
- Bypass:
  - value(a) = IN when WRITE=1, CLEAR=0 and INaddr == a (write-first).
  - Otherwise value(a) = reg[a].
  - Both ports may bypass in the same cycle.
- ZERO_REG=1:
  - value(0) = 0 always, including during bypass.
  - A write to address 0 is discarded.
- CLEAR at posedge:
  - All registers <= 0.
  - A simultaneous WRITE is ignored; CLEAR wins.
  - A simultaneous READ returns 0 on both ports with OUT_VALID=1.
- Same-address reads on OUT1addr and OUT2addr are legal; both ports return identical data.
- RESET mid-operation (asserted between edges): state clears immediately and the in-flight read is lost (OUT_VALID=0).
- Width rules:
  - IN is stored verbatim; no truncation or extension inside the block.
  - Address decode is exact: every ADDR_W value maps to a register, so there are no out-of-range addresses.
- Implementation: flop array of DEPTH x DATA_W; no latches, no negedge logic.

Test Plan:
1. Reset, then READ=1 with OUT1addr=3, OUT2addr=5 -> next edge OUT1=0, OUT2=0, OUT_VALID=1.
2. WRITE IN=0x2A to reg 3; next cycle READ OUT1addr=3 -> OUT1=0x2A one cycle after the read edge. Then READ=0 -> OUT1 holds 0x2A and OUT_VALID=0.
3. Bypass: same edge WRITE IN=0x55 to INaddr=6 with READ OUT1addr=6, OUT2addr=6 -> both outputs 0x55. With WRITE=0 on the same edge, reg 6 is unchanged and the old value is read.
4. ZERO_REG=1 bench: WRITE 0xFF to reg 0, then READ addr 0 -> 0, including the same-edge bypass case. With ZERO_REG=0 the same sequence reads 0xFF.
5. CLEAR with a simultaneous WRITE 0x11 to reg 2 and READ addr 2 -> OUT1=0 and OUT_VALID=1. A subsequent read of any register returns 0.
6. Parameter sweep DATA_W=16, ADDR_W=5: write 0xBEEF to reg 31 and 0x1234 to reg 0, read both ports -> 0xBEEF / 0x1234. Assert RESET mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports with write-first bypass,
// one write port, synchronous clear-all and an optional hardwired zero register.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INaddr,
    input  logic [DATA_W-1:0] IN,
    input  logic              READ,
    input  logic [ADDR_W-1:0] OUT1addr,
    input  logic [ADDR_W-1:0] OUT2addr,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT_VALID
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_en;
    logic [DATA_W-1:0] rd1_value;
    logic [DATA_W-1:0] rd2_value;

    // A write to register 0 is dropped when it is hardwired to zero.
    assign write_en = WRITE && !CLEAR && !((ZERO_REG != 0) && (INaddr == '0));

    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        rd1_value = regs[OUT1addr];
        rd2_value = regs[OUT2addr];
        if (WRITE && INaddr == OUT1addr) rd1_value = IN;
        if (WRITE && INaddr == OUT2addr) rd2_value = IN;
        if ((ZERO_REG != 0) && OUT1addr == '0) rd1_value = '0;
        if ((ZERO_REG != 0) && OUT2addr == '0) rd2_value = '0;
        // Clear wins over both the stored contents and the bypassed write data.
        if (CLEAR) begin
            rd1_value = '0;
            rd2_value = '0;
        end
    end

    // NOTE: the array is reset along with the rest of the state because the
    // block must read 0 everywhere after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (write_en) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            regs[INaddr] <= IN;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            OUT1      <= '0;
            OUT2      <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= READ;
            if (READ) begin
                OUT1 <= rd1_value;
                OUT2 <= rd2_value;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three instances (8x8, 8x8 with zero
// register, 16x32) share address/data buses but have private enables.
module tb_reg_file_param;

    typedef struct packed {
        logic [15:0] o1;
        logic [15:0] o2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  clr, wr, rd;
    logic [4:0]  in_addr, a1_addr, a2_addr;
    logic [15:0] in_data;

    logic [7:0]  a_out1, a_out2, b_out1, b_out2;
    logic [15:0] c_out1, c_out2;
    logic        a_valid, b_valid, c_valid;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_a (
        .clk(clk), .RESET(reset), .CLEAR(clr[0]), .WRITE(wr[0]),
        .INaddr(in_addr[2:0]), .IN(in_data[7:0]), .READ(rd[0]),
        .OUT1addr(a1_addr[2:0]), .OUT2addr(a2_addr[2:0]),
        .OUT1(a_out1), .OUT2(a_out2), .OUT_VALID(a_valid)
    );

    reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_b (
        .clk(clk), .RESET(reset), .CLEAR(clr[1]), .WRITE(wr[1]),
        .INaddr(in_addr[2:0]), .IN(in_data[7:0]), .READ(rd[1]),
        .OUT1addr(a1_addr[2:0]), .OUT2addr(a2_addr[2:0]),
        .OUT1(b_out1), .OUT2(b_out2), .OUT_VALID(b_valid)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0)) dut_c (
        .clk(clk), .RESET(reset), .CLEAR(clr[2]), .WRITE(wr[2]),
        .INaddr(in_addr), .IN(in_data), .READ(rd[2]),
        .OUT1addr(a1_addr), .OUT2addr(a2_addr),
        .OUT1(c_out1), .OUT2(c_out2), .OUT_VALID(c_valid)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whenever an instance presents valid data, pop its expectation.
    task automatic monitor(input int d, input logic [15:0] o1, input logic [15:0] o2);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got %h/%h expected no data", d, o1, o2);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("dut%0d.out1", d), o1, e.o1);
            check($sformatf("dut%0d.out2", d), o2, e.o2);
        end
    endtask

    always @(negedge clk) begin
        if (a_valid === 1'b1) monitor(0, {8'h00, a_out1}, {8'h00, a_out2});
        if (b_valid === 1'b1) monitor(1, {8'h00, b_out1}, {8'h00, b_out2});
        if (c_valid === 1'b1) monitor(2, c_out1, c_out2);
    end

    // One clock cycle of stimulus on instance d; a read queues its expectation.
    task automatic op(input int d, input bit w, input logic [4:0] wa, input logic [15:0] wd,
                      input bit r, input logic [4:0] ra1, input logic [4:0] ra2, input bit c,
                      input logic [15:0] e1, input logic [15:0] e2);
        exp_t e;
        wr[d]   = w;
        rd[d]   = r;
        clr[d]  = c;
        in_addr = wa;
        in_data = wd;
        a1_addr = ra1;
        a2_addr = ra2;
        if (r) begin
            e.o1 = e1;
            e.o2 = e2;
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        wr  = '0;
        rd  = '0;
        clr = '0;
    endtask

    initial begin
        reset   = 1'b1;
        clr     = '0;
        wr      = '0;
        rd      = '0;
        in_addr = '0;
        in_data = '0;
        a1_addr = '0;
        a2_addr = '0;
        #12;
        check("reset.a_out1", {8'h00, a_out1}, 16'h0000);
        check("reset.a_valid", {15'h0, a_valid}, 16'h0000);
        check("reset.c_out2", c_out2, 16'h0000);
        reset = 1'b0;

        // Read straight after reset returns zeros.
        op(0, 0, 0, 0,       1, 3, 5, 0, 16'h0000, 16'h0000);

        // Write then read, then idle hold.
        op(0, 1, 3, 16'h2A,  0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0,       1, 3, 5, 0, 16'h002A, 16'h0000);
        op(0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        check("idle.a_out1_hold", {8'h00, a_out1}, 16'h002A);
        check("idle.a_valid", {15'h0, a_valid}, 16'h0000);

        // Bypass on both ports; WRITE=0 leaves reg 6 alone; bypass on one port only.
        op(0, 1, 6, 16'h55,  1, 6, 6, 0, 16'h0055, 16'h0055);
        op(0, 0, 6, 16'h77,  1, 6, 6, 0, 16'h0055, 16'h0055);
        op(0, 1, 1, 16'h10,  1, 6, 1, 0, 16'h0055, 16'h0010);

        // Hardwired zero register versus ordinary register 0.
        op(1, 1, 0, 16'hFF,  0, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0,       1, 0, 0, 0, 16'h0000, 16'h0000);
        op(1, 1, 0, 16'hFF,  1, 0, 0, 0, 16'h0000, 16'h0000);
        op(1, 1, 4, 16'h9C,  1, 4, 0, 0, 16'h009C, 16'h0000);
        op(0, 1, 0, 16'hFF,  0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0,       1, 0, 0, 0, 16'h00FF, 16'h00FF);
        op(0, 1, 0, 16'hAB,  1, 0, 3, 0, 16'h00AB, 16'h002A);

        // Clear beats a simultaneous write; everything reads 0 afterwards.
        op(0, 1, 2, 16'h11,  1, 2, 3, 1, 16'h0000, 16'h0000);
        op(0, 0, 0, 0,       1, 3, 6, 0, 16'h0000, 16'h0000);
        op(0, 0, 0, 0,       1, 0, 2, 0, 16'h0000, 16'h0000);

        // Wide instance: top and bottom registers.
        op(2, 1, 31, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        op(2, 1, 0,  16'h1234, 0, 0, 0, 0, 0, 0);
        op(2, 0, 0,  0,        1, 31, 0, 0, 16'hBEEF, 16'h1234);
        op(2, 0, 0,  0,        1, 0, 31, 0, 16'h1234, 16'hBEEF);

        // Reset between edges discards the read that just completed.
        rd[2]   = 1'b1;
        a1_addr = 5'd31;
        a2_addr = 5'd0;
        @(posedge clk);
        #1;
        rd[2] = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset.c_out1", c_out1, 16'h0000);
        check("midreset.c_out2", c_out2, 16'h0000);
        check("midreset.c_valid", {15'h0, c_valid}, 16'h0000);
        #1;
        reset = 1'b0;
        op(2, 0, 0, 0,       1, 31, 0, 0, 16'h0000, 16'h0000);
        op(0, 0, 0, 0,       1, 0, 1, 0, 16'h0000, 16'h0000);
        op(0, 0, 0, 0,       0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        check("drain.q0", 16'(q0.size()), 16'h0000);
        check("drain.q1", 16'(q1.size()), 16'h0000);
        check("drain.q2", 16'(q2.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
